bdemux_4_buf: RTL and testbench

- Distribution counterpart to the 4-way source select in the datapath.
- Accepts one WIDTH-bit word with a 2-bit destination select and routes it into one of four single-entry holding registers, or into all four in broadcast mode.
- Each destination drains independently through its own valid/ready handshake.
- Sits between the ALU/memory result bus and the four write-back consumers: register file, PC, memory-data, I/O.

---
 rtl/bdemux_4_buf_pkg.sv | 24 ++
 rtl/bdemux_4_buf_slot.sv | 57 +++++
 rtl/bdemux_4_buf.sv | 102 ++++++++++
 tb/tb_bdemux_4_buf.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bdemux_4_buf_pkg.sv
// Shared definitions for the 4-way buffered demultiplexer: destination encodings,
// the one-hot write-enable type and a popcount helper for slot occupancy.
package bdemux_4_buf_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int NUM_DEST      = 4;

  localparam logic [1:0] DEST_A = 2'd0;
  localparam logic [1:0] DEST_B = 2'd1;
  localparam logic [1:0] DEST_C = 2'd2;
  localparam logic [1:0] DEST_D = 2'd3;

  typedef logic [NUM_DEST-1:0] dest_onehot_t;

  function automatic logic [2:0] popcount4(input dest_onehot_t bits);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < NUM_DEST; i++) begin
      cnt = cnt + {2'b00, bits[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bdemux_4_buf_slot.sv
// One single-entry holding register with a valid/ready drain port.
// A write takes priority over a drain, so a slot being emptied can be refilled at the same edge.
module bdemux_slot
  import bdemux_4_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t state;

  // Slot state machine and held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      data  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (wr_en) begin
            state <= FULL;
            data  <= wr_data;
          end else begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (wr_en) begin
            state <= FULL;
            data  <= wr_data;
          end else if (rd_ready) begin
            state <= EMPTY;
          end else begin
            state <= FULL;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  assign valid = (state == FULL);
  assign free  = (state == EMPTY) | rd_ready;

endmodule

// File: rtl/bdemux_4_buf.sv
// Routes one word into one of four 1-deep destination buffers (or all four on broadcast);
// each destination drains through its own valid/ready handshake.
module bdemux_4_buf
  import bdemux_4_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic             in_bcast,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [WIDTH-1:0] c_data,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [WIDTH-1:0] d_data,
  output logic [2:0]       occupancy
);

  dest_onehot_t     free;
  dest_onehot_t     valid;
  dest_onehot_t     ready;
  dest_onehot_t     wr_en;
  dest_onehot_t     sel_onehot;
  dest_onehot_t     next_valid;
  logic             accept;
  logic [WIDTH-1:0] data [NUM_DEST];

  assign ready = {d_ready, c_ready, b_ready, a_ready};

  // Destination decode, in_ready mux and write-enable generation.
  always_comb begin
    sel_onehot = '0;
    case (in_sel)
      DEST_A:  sel_onehot = 4'b0001;
      DEST_B:  sel_onehot = 4'b0010;
      DEST_C:  sel_onehot = 4'b0100;
      DEST_D:  sel_onehot = 4'b1000;
      default: sel_onehot = 4'b0000;
    endcase

    if (in_bcast) begin
      in_ready = &free;
    end else begin
      in_ready = |(free & sel_onehot);
    end

    accept = in_valid & in_ready;
    if (!accept) begin
      wr_en = '0;
    end else if (in_bcast) begin
      wr_en = '1;
    end else begin
      wr_en = sel_onehot;
    end

    // Valid bits as they will stand after the coming edge, so occupancy tracks them exactly.
    next_valid = wr_en | (valid & ~ready);
  end

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_slot
    bdemux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[i]),
      .wr_data  (in_data),
      .rd_ready (ready[i]),
      .valid    (valid[i]),
      .data     (data[i]),
      .free     (free[i])
    );
  end

  // Registered count of occupied slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= 3'd0;
    end else begin
      occupancy <= popcount4(next_valid);
    end
  end

  assign a_valid = valid[0];
  assign b_valid = valid[1];
  assign c_valid = valid[2];
  assign d_valid = valid[3];
  assign a_data  = data[0];
  assign b_data  = data[1];
  assign c_data  = data[2];
  assign d_data  = data[3];

endmodule

// File: tb/tb_bdemux_4_buf.sv
// Directed bench for bdemux_4_buf: a slot-array model checked every cycle,
// plus hand-computed literal expectations from the test plan.
module tb_bdemux_4_buf;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_sel = 2'd0;
  logic         in_bcast = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         a_valid, b_valid, c_valid, d_valid;
  logic         a_ready = 1'b0, b_ready = 1'b0, c_ready = 1'b0, d_ready = 1'b0;
  logic [W-1:0] a_data, b_data, c_data, d_data;
  logic [2:0]   occupancy;

  int vectors = 0;
  int miscompares = 0;

  // model: one valid flag and one word per destination
  logic         mv [4];
  logic [W-1:0] md [4];

  bdemux_4_buf #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_data(in_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic rdy_of(input int i);
    case (i)
      0: return a_ready;
      1: return b_ready;
      2: return c_ready;
      default: return d_ready;
    endcase
  endfunction

  function automatic logic model_in_ready();
    logic all_free;
    all_free = 1'b1;
    for (int i = 0; i < 4; i++) all_free = all_free & (!mv[i] || rdy_of(i));
    if (in_bcast) return all_free;
    return !mv[in_sel] || rdy_of(int'(in_sel));
  endfunction

  function automatic int model_occ();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += int'(mv[i]);
    return n;
  endfunction

  // Model update: acceptance and drains evaluated from values present at the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] <= 1'b0;
        md[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid && model_in_ready() && (in_bcast || int'(in_sel) == i)) begin
          mv[i] <= 1'b1;
          md[i] <= in_data;
        end else if (rdy_of(i)) begin
          mv[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic         v [4];
    logic [W-1:0] d [4];
    v = '{a_valid, b_valid, c_valid, d_valid};
    d = '{a_data, b_data, c_data, d_data};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("valid[%0d]", i), {31'd0, v[i]}, {31'd0, mv[i]});
      if (mv[i]) chk($sformatf("data[%0d]", i), {16'd0, d[i]}, {16'd0, md[i]});
    end
    chk("occupancy", {29'd0, occupancy}, model_occ());
    chk("in_ready", {31'd0, in_ready}, {31'd0, model_in_ready()});
  endtask

  // Inputs are set just after a negedge; settle, check in_ready, take the edge, check state.
  task automatic tick();
    #1;
    chk("in_ready_pre", {31'd0, in_ready}, {31'd0, model_in_ready()});
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic offer(input logic [1:0] sel, input logic bc, input logic [W-1:0] dat);
    in_valid = 1'b1;
    in_sel   = sel;
    in_bcast = bc;
    in_data  = dat;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_bcast = 1'b0;
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    @(negedge clk);
    compare_all();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_occ", {29'd0, occupancy}, 32'd0);
    chk("rst_data", {a_data, b_data} | {c_data, d_data}, 32'd0);
    chk("rst_valid", {28'd0, a_valid, b_valid, c_valid, d_valid}, 32'd0);

    // basic routing to C
    offer(2'd2, 1'b0, 16'hBEEF);
    tick();
    idle();
    chk("route_c_valid", {31'd0, c_valid}, 32'd1);
    chk("route_c_data", {16'd0, c_data}, 32'h0000_BEEF);
    chk("route_others", {29'd0, a_valid, b_valid, d_valid}, 32'd0);
    chk("route_occ", {29'd0, occupancy}, 32'd1);

    // back-pressure on C, then same-cycle refill
    offer(2'd2, 1'b0, 16'h1234);
    #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_hold", {16'd0, c_data}, 32'h0000_BEEF);
    c_ready = 1'b1;
    #1 chk("refill_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    c_ready = 1'b0;
    idle();
    chk("refill_data", {16'd0, c_data}, 32'h0000_1234);
    chk("refill_valid", {31'd0, c_valid}, 32'd1);
    chk("refill_occ", {29'd0, occupancy}, 32'd1);

    // independence: A accepts while C stalls
    offer(2'd0, 1'b0, 16'h0001);
    #1 chk("indep_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    idle();
    chk("indep_a_data", {16'd0, a_data}, 32'h0000_0001);
    chk("indep_occ", {29'd0, occupancy}, 32'd2);

    // ready with nothing held has no effect
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;

    // drain A and C, fill B, then broadcast blocked by stalled B
    a_ready = 1'b1;
    c_ready = 1'b1;
    offer(2'd1, 1'b0, 16'h7777);
    tick();
    a_ready = 1'b0;
    c_ready = 1'b0;
    offer(2'd3, 1'b1, 16'h5A5A);
    #1 chk("bcast_block", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bcast_b_hold", {16'd0, b_data}, 32'h0000_7777);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    idle();
    chk("bcast_data", {a_data, d_data} ^ {c_data, b_data}, 32'd0);
    chk("bcast_word", {16'd0, a_data}, 32'h0000_5A5A);
    chk("bcast_occ", {29'd0, occupancy}, 32'd4);

    // drain everything
    {a_ready, b_ready, c_ready, d_ready} = 4'hF;
    tick();
    {a_ready, b_ready, c_ready, d_ready} = 4'h0;
    chk("drain_valid", {28'd0, a_valid, b_valid, c_valid, d_valid}, 32'd0);
    chk("drain_occ", {29'd0, occupancy}, 32'd0);

    // mid-cycle asynchronous reset with C full
    offer(2'd2, 1'b0, 16'hCAFE);
    tick();
    idle();
    chk("pre_rst_c_valid", {31'd0, c_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_c_valid", {31'd0, c_valid}, 32'd0);
    chk("async_rst_occ", {29'd0, occupancy}, 32'd0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("no_replay", {31'd0, c_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
